frame_draw_scheduler: RTL

Sequences the drawing of one video frame onto the VGA write port. Each frame has two phases. First, a full 160x120 raster sweep drives the background renderer's coordinates and writes its colour output. Second, the note-block renderer gets exclusive access to the write port through a req/ack handshake. Sits between the keyboard/drum/piano background renderer, the falling-note renderer and the VGA adapter; it replaces free-running scan counters so that note blocks are always drawn on top of a completed background.

---
 rtl/frame_draw_scheduler.sv | 131 +++++++++++++
 1 files changed

// File: rtl/frame_draw_scheduler.sv
// Frame sequencer for the VGA write port: a full background raster sweep, a pipeline
// drain, then exclusive note-pixel writes through a req/ack handshake.
`timescale 1ns/1ps
`ifndef STARTSCREEN
`define STARTSCREEN 5'd0
`endif

module frame_draw_scheduler #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frameTick,
  input  logic [4:0]  currentState,
  output logic [7:0]  scanX,
  output logic [7:0]  scanY,
  input  logic [23:0] bgColour,
  input  logic        noteReq,
  input  logic [7:0]  noteX,
  input  logic [7:0]  noteY,
  input  logic [23:0] noteColour,
  input  logic        noteDone,
  output logic        noteAck,
  output logic [7:0]  vgaX,
  output logic [7:0]  vgaY,
  output logic [23:0] vgaColour,
  output logic        vgaPlot,
  output logic        busy,
  output logic        frameDone,
  output logic        frameOverrun
);

  localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
  localparam logic [7:0] Y_LAST = 8'(HEIGHT - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, FLUSH, NOTES, DONE} state_t;

  state_t     state;
  state_t     nextState;
  logic       abort;
  logic       scanLast;
  logic       noteTake;
  logic       noteInRange;
  logic       flushCnt;
  logic       vld_p1;
  logic [7:0] x_p1;
  logic [7:0] y_p1;

  assign abort       = (state != IDLE) && (currentState == `STARTSCREEN);
  assign scanLast    = (scanX == X_LAST) && (scanY == Y_LAST);
  assign noteTake    = (state == NOTES) && noteReq && !noteAck && !abort;
  assign noteInRange = ({24'd0, noteX} < 32'(WIDTH)) && ({24'd0, noteY} < 32'(HEIGHT));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (frameTick && currentState != `STARTSCREEN) nextState = CLEAR;
      CLEAR:   if (scanLast) nextState = FLUSH;
      FLUSH:   if (flushCnt) nextState = NOTES;
      NOTES:   if (noteDone && !noteReq && !noteAck) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (abort) nextState = IDLE;
  end

  always_comb begin
    busy      = (state != IDLE);
    frameDone = (state == DONE);
  end

  // Stage p0 -> p1: coordinate presented to the ROM travels alongside its colour lookup.
  always_ff @(posedge clk) begin
    x_p1 <= scanX;
    y_p1 <= scanY;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scanX        <= 8'd0;
      scanY        <= 8'd0;
      flushCnt     <= 1'b0;
      vld_p1       <= 1'b0;
      noteAck      <= 1'b0;
      frameOverrun <= 1'b0;
      vgaX         <= 8'd0;
      vgaY         <= 8'd0;
      vgaColour    <= 24'd0;
      vgaPlot      <= 1'b0;
    end else begin
      if (state == CLEAR && nextState == CLEAR) begin
        if (scanX == X_LAST) begin
          scanX <= 8'd0;
          scanY <= scanY + 8'd1;
        end else begin
          scanX <= scanX + 8'd1;
        end
      end else begin
        scanX <= 8'd0;
        scanY <= 8'd0;
      end
      flushCnt     <= (state == FLUSH) && (nextState == FLUSH);
      vld_p1       <= (state == CLEAR) && !abort;
      noteAck      <= noteTake;
      frameOverrun <= frameOverrun | (frameTick && state != IDLE);
      // Stage p1 -> write port: background pixel (with ROM colour) or accepted note pixel.
      if (abort) begin
        vgaPlot <= 1'b0;
      end else if (vld_p1) begin
        vgaX      <= x_p1;
        vgaY      <= y_p1;
        vgaColour <= bgColour;
        vgaPlot   <= 1'b1;
      end else if (noteTake) begin
        vgaX      <= noteX;
        vgaY      <= noteY;
        vgaColour <= noteColour;
        vgaPlot   <= noteInRange;
      end else begin
        vgaPlot <= 1'b0;
      end
    end
  end

endmodule
